// File: rtl/list_ctrl_lru_responder.sv
// Dual-port LRU age-list responder: one permutation of ages per set, updated by
// promote/allocate/invalidate/query commands with a one-cycle registered response.
module list_ctrl_lru_responder #(
  parameter int lists_depth = 4,
  parameter int index_lenth = 4,
  localparam int TW = $clog2(lists_depth)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   acc_req_0,
  input  logic [1:0]             acc_cmd_0,
  input  logic [index_lenth-1:0] acc_index_0,
  input  logic [TW-1:0]          acc_tag_0,
  output logic [TW-1:0]          return_tag_0,
  output logic [2:0]             acc_status_0,
  input  logic                   acc_req_1,
  input  logic [1:0]             acc_cmd_1,
  input  logic [index_lenth-1:0] acc_index_1,
  input  logic [TW-1:0]          acc_tag_1,
  output logic [TW-1:0]          return_tag_1,
  output logic [2:0]             acc_status_1
);

  localparam int NSETS = 2 ** index_lenth;
  localparam logic [1:0] CMD_HIT   = 2'b00;
  localparam logic [1:0] CMD_ALLOC = 2'b01;
  localparam logic [1:0] CMD_INVAL = 2'b10;
  localparam logic [1:0] CMD_QUERY = 2'b11;

  typedef logic [lists_depth-1:0][TW-1:0] age_set_t;
  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                 state;
  logic [index_lenth-1:0] cnt;
  age_set_t               age_mem [NSETS];
  age_set_t               init_set;

  age_set_t      ages0, ages1, new0, new1;
  logic [TW-1:0] tgt0, tgt1;
  logic          mru0, mru1;

  // Way w starts with age lists_depth-1-w, so way 0 is the first victim.
  for (genvar gi = 0; gi < lists_depth; gi++) begin : g_init
    assign init_set[gi] = TW'(lists_depth - 1 - gi);
  end

  function automatic logic [TW-1:0] find_lru(input age_set_t ages);
    logic [TW-1:0] r;
    r = '0;
    for (int w = 0; w < lists_depth; w++)
      if (ages[w] == TW'(lists_depth - 1)) r = TW'(w);
    return r;
  endfunction

  function automatic logic [TW-1:0] pick_target(input age_set_t ages,
                                                input logic [1:0] cmd,
                                                input logic [TW-1:0] tag);
    if (cmd == CMD_ALLOC || cmd == CMD_QUERY) return find_lru(ages);
    return tag;
  endfunction

  function automatic age_set_t apply_cmd(input age_set_t ages,
                                         input logic [1:0] cmd,
                                         input logic [TW-1:0] t);
    age_set_t      r;
    logic [TW-1:0] a;
    r = ages;
    a = ages[t];
    for (int w = 0; w < lists_depth; w++) begin
      if (cmd == CMD_HIT || cmd == CMD_ALLOC) begin
        if (TW'(w) == t)    r[w] = '0;
        else if (ages[w] < a) r[w] = ages[w] + 1'b1;
      end else if (cmd == CMD_INVAL) begin
        if (TW'(w) == t)    r[w] = TW'(lists_depth - 1);
        else if (ages[w] > a) r[w] = ages[w] - 1'b1;
      end
    end
    return r;
  endfunction

  // Port 1 sees port 0's result when both target the same set this cycle.
  always_comb begin
    ages0 = age_mem[acc_index_0];
    tgt0  = pick_target(ages0, acc_cmd_0, acc_tag_0);
    new0  = apply_cmd(ages0, acc_cmd_0, tgt0);
    mru0  = (acc_cmd_0 != CMD_QUERY) && (ages0[tgt0] == '0);
    ages1 = (acc_req_0 && (acc_index_0 == acc_index_1)) ? new0 : age_mem[acc_index_1];
    tgt1  = pick_target(ages1, acc_cmd_1, acc_tag_1);
    new1  = apply_cmd(ages1, acc_cmd_1, tgt1);
    mru1  = (acc_cmd_1 != CMD_QUERY) && (ages1[tgt1] == '0);
  end

  // Port 1 is written last so a same-set write carries both updates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) begin
        age_mem[cnt] <= init_set;
      end else begin
        if (acc_req_0) age_mem[acc_index_0] <= new0;
        if (acc_req_1) age_mem[acc_index_1] <= new1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_INIT;
      cnt          <= '0;
      return_tag_0 <= '0;
      acc_status_0 <= '0;
      return_tag_1 <= '0;
      acc_status_1 <= '0;
    end else begin
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == index_lenth'(NSETS - 1)) state <= S_READY;
          if (acc_req_0) begin
            acc_status_0 <= 3'b011;
            return_tag_0 <= '0;
          end else begin
            acc_status_0 <= 3'b000;
          end
          if (acc_req_1) begin
            acc_status_1 <= 3'b011;
            return_tag_1 <= '0;
          end else begin
            acc_status_1 <= 3'b000;
          end
        end
        S_READY: begin
          if (acc_req_0) begin
            acc_status_0 <= {mru0, 2'b01};
            return_tag_0 <= tgt0;
          end else begin
            acc_status_0 <= 3'b000;
          end
          if (acc_req_1) begin
            acc_status_1 <= {mru1, 2'b01};
            return_tag_1 <= tgt1;
          end else begin
            acc_status_1 <= 3'b000;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_list_ctrl_lru_responder.sv
// Directed bench for list_ctrl_lru_responder (lists_depth=4, index_lenth=4).
module tb_list_ctrl_lru_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       acc_req_0, acc_req_1;
  logic [1:0] acc_cmd_0, acc_cmd_1;
  logic [3:0] acc_index_0, acc_index_1;
  logic [1:0] acc_tag_0, acc_tag_1;
  logic [1:0] return_tag_0, return_tag_1;
  logic [2:0] acc_status_0, acc_status_1;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] HIT = 2'b00, ALLOC = 2'b01, INVAL = 2'b10, QUERY = 2'b11;

  list_ctrl_lru_responder #(.lists_depth(4), .index_lenth(4)) dut (
    .clk(clk), .rst(rst),
    .acc_req_0(acc_req_0), .acc_cmd_0(acc_cmd_0), .acc_index_0(acc_index_0),
    .acc_tag_0(acc_tag_0), .return_tag_0(return_tag_0), .acc_status_0(acc_status_0),
    .acc_req_1(acc_req_1), .acc_cmd_1(acc_cmd_1), .acc_index_1(acc_index_1),
    .acc_tag_1(acc_tag_1), .return_tag_1(return_tag_1), .acc_status_1(acc_status_1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the edge; outputs are read at the same point.
  task automatic step(input logic r0, input logic [1:0] c0, input logic [3:0] i0, input logic [1:0] t0,
                      input logic r1, input logic [1:0] c1, input logic [3:0] i1, input logic [1:0] t1);
    acc_req_0 = r0; acc_cmd_0 = c0; acc_index_0 = i0; acc_tag_0 = t0;
    acc_req_1 = r1; acc_cmd_1 = c1; acc_index_1 = i1; acc_tag_1 = t1;
    @(posedge clk);
    #1;
    acc_req_0 = 1'b0;
    acc_req_1 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, HIT, 0, 0, 0, HIT, 0, 0);
  endtask

  task automatic test_reset_and_init();
    rst = 1'b1;
    step(0, HIT, 0, 0, 0, HIT, 0, 0);
    rst = 1'b0;
    checks++;
    if (acc_status_0 !== 3'b000 || return_tag_0 !== 2'd0 || acc_status_1 !== 3'b000 || return_tag_1 !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: st0=%b ret0=%0d st1=%b ret1=%0d expected all 0",
               acc_status_0, return_tag_0, acc_status_1, return_tag_1);
    end
    idle(4);
    step(1, ALLOC, 2, 0, 0, HIT, 0, 0);
    checks++;
    if (acc_status_0 !== 3'b011 || return_tag_0 !== 2'd0) begin
      errors++;
      $display("FAIL init_busy_c5: st=%b ret=%0d expected 011 ret 0", acc_status_0, return_tag_0);
    end
    idle(1);
    checks++;
    if (acc_status_0 !== 3'b000 || return_tag_0 !== 2'd0) begin
      errors++;
      $display("FAIL idle_after_busy: st=%b ret=%0d expected 000 ret 0", acc_status_0, return_tag_0);
    end
    idle(9);
    step(0, HIT, 0, 0, 1, QUERY, 0, 0);
    checks++;
    if (acc_status_1 !== 3'b011) begin
      errors++;
      $display("FAIL init_busy_c16: st1=%b expected 011", acc_status_1);
    end
    step(1, QUERY, 0, 0, 0, HIT, 0, 0);
    checks++;
    if (acc_status_0 !== 3'b001 || return_tag_0 !== 2'd0) begin
      errors++;
      $display("FAIL first_ready_c17: st=%b ret=%0d expected 001 ret 0", acc_status_0, return_tag_0);
    end
    $display("test_reset_and_init done");
  endtask

  task automatic test_alloc_sequence();
    logic [1:0] exp_ret [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 5; k++) begin
      step(1, ALLOC, 3, 0, 0, HIT, 0, 0);
      checks++;
      if (acc_status_0 !== 3'b001 || return_tag_0 !== exp_ret[k]) begin
        errors++;
        $display("FAIL alloc_seq[%0d]: st=%b ret=%0d expected 001 ret %0d", k, acc_status_0, return_tag_0, exp_ret[k]);
      end
    end
    idle(1);
    checks++;
    if (acc_status_0 !== 3'b000 || return_tag_0 !== 2'd0) begin
      errors++;
      $display("FAIL ret_hold: st=%b ret=%0d expected 000 ret 0 held", acc_status_0, return_tag_0);
    end
    $display("test_alloc_sequence done");
  endtask

  task automatic test_hit_promote();
    step(1, HIT, 3, 1, 0, HIT, 0, 0);
    checks++;
    if (acc_status_0 !== 3'b001 || return_tag_0 !== 2'd1) begin
      errors++;
      $display("FAIL hit_tag1: st=%b ret=%0d expected 001 ret 1", acc_status_0, return_tag_0);
    end
    step(1, ALLOC, 3, 0, 0, HIT, 0, 0);
    checks++;
    if (acc_status_0 !== 3'b001 || return_tag_0 !== 2'd2) begin
      errors++;
      $display("FAIL alloc_after_hit: st=%b ret=%0d expected 001 ret 2", acc_status_0, return_tag_0);
    end
    step(1, HIT, 3, 2, 0, HIT, 0, 0);
    checks++;
    if (acc_status_0 !== 3'b101 || return_tag_0 !== 2'd2) begin
      errors++;
      $display("FAIL hit_mru: st=%b ret=%0d expected 101 ret 2", acc_status_0, return_tag_0);
    end
    $display("test_hit_promote done");
  endtask

  task automatic test_inval_query();
    step(0, HIT, 0, 0, 1, INVAL, 7, 3);
    checks++;
    if (acc_status_1 !== 3'b101 || return_tag_1 !== 2'd3) begin
      errors++;
      $display("FAIL inval_tag3: st1=%b ret1=%0d expected 101 ret 3", acc_status_1, return_tag_1);
    end
    step(1, QUERY, 7, 0, 0, HIT, 0, 0);
    checks++;
    if (acc_status_0 !== 3'b001 || return_tag_0 !== 2'd3) begin
      errors++;
      $display("FAIL query1: st=%b ret=%0d expected 001 ret 3", acc_status_0, return_tag_0);
    end
    step(1, QUERY, 7, 0, 0, HIT, 0, 0);
    checks++;
    if (acc_status_0 !== 3'b001 || return_tag_0 !== 2'd3) begin
      errors++;
      $display("FAIL query2: st=%b ret=%0d expected 001 ret 3", acc_status_0, return_tag_0);
    end
    // After the invalidate way 2 holds age 0, so a hit on it reports was_mru.
    step(1, HIT, 7, 2, 0, HIT, 0, 0);
    checks++;
    if (acc_status_0 !== 3'b101 || return_tag_0 !== 2'd2) begin
      errors++;
      $display("FAIL post_query_ages: st=%b ret=%0d expected 101 ret 2", acc_status_0, return_tag_0);
    end
    $display("test_inval_query done");
  endtask

  task automatic test_back_to_back();
    step(1, ALLOC, 5, 0, 1, ALLOC, 5, 0);
    checks++;
    if (acc_status_0 !== 3'b001 || return_tag_0 !== 2'd0 || acc_status_1 !== 3'b001 || return_tag_1 !== 2'd1) begin
      errors++;
      $display("FAIL same_idx_alloc: st0=%b ret0=%0d st1=%b ret1=%0d expected 001/0 001/1",
               acc_status_0, return_tag_0, acc_status_1, return_tag_1);
    end
    step(1, QUERY, 5, 0, 1, ALLOC, 9, 0);
    checks++;
    if (return_tag_0 !== 2'd2 || return_tag_1 !== 2'd0 || acc_status_1 !== 3'b001) begin
      errors++;
      $display("FAIL query_after_dual: ret0=%0d ret1=%0d st1=%b expected ret0 2 ret1 0 st1 001",
               return_tag_0, return_tag_1, acc_status_1);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_traffic();
    int bad;
    rst = 1'b1;
    step(1, ALLOC, 9, 0, 1, ALLOC, 3, 0);
    rst = 1'b0;
    checks++;
    if (acc_status_0 !== 3'b000 || return_tag_0 !== 2'd0 || acc_status_1 !== 3'b000 || return_tag_1 !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_traffic: st0=%b ret0=%0d st1=%b ret1=%0d expected all 0",
               acc_status_0, return_tag_0, acc_status_1, return_tag_1);
    end
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      step(1, ALLOC, 9, 0, 1, HIT, 3, 1);
      if (acc_status_0 !== 3'b011 || acc_status_1 !== 3'b011 || return_tag_0 !== 2'd0 || return_tag_1 !== 2'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reinit_busy: %0d of 16 cycles not 011/ret 0", bad);
    end
    step(1, ALLOC, 9, 0, 1, ALLOC, 3, 0);
    checks++;
    if (acc_status_0 !== 3'b001 || return_tag_0 !== 2'd0 || acc_status_1 !== 3'b001 || return_tag_1 !== 2'd0) begin
      errors++;
      $display("FAIL alloc_after_reinit: st0=%b ret0=%0d st1=%b ret1=%0d expected 001/0 001/0",
               acc_status_0, return_tag_0, acc_status_1, return_tag_1);
    end
    $display("test_reset_mid_traffic done");
  endtask

  initial begin
    rst = 1'b0;
    acc_req_0 = 0; acc_cmd_0 = 0; acc_index_0 = 0; acc_tag_0 = 0;
    acc_req_1 = 0; acc_cmd_1 = 0; acc_index_1 = 0; acc_tag_1 = 0;
    @(posedge clk);
    #1;
    test_reset_and_init();
    test_alloc_sequence();
    test_hit_promote();
    test_inval_query();
    test_back_to_back();
    test_reset_mid_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
